// File: rtl/dataexch_pkg.sv
// Shared types and defaults for the A/B and C/D exchange-buffer direction controller.
package dataexch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_TURN = 2'd2
  } chanState_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  localparam int TURN_CYC_DEF  = 2;
  localparam int BURST_MAX_DEF = 16;
  localparam int CNT_W_DEF     = 8;

endpackage

// File: rtl/dataexch_dirctl_chan.sv
// One channel's direction arbiter: grants forward/reverse, inserts turnaround dead cycles, bounds bursts.
// Latency: grant 1 cycle after request, TURN_CYC+1 after a direction change; strobes without a grant are ignored.
module dirctl_chan
  import dataexch_pkg::*;
#(
  parameter int TURN_CYC  = TURN_CYC_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic fwdReq,
  input  logic revReq,
  input  logic stb,
  output logic oe,
  output logic gntFwd,
  output logic gntRev
);

  localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_CYC);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

  chanState_t       state, stateNxt;
  logic             dir, dirNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic             wantReq, oppReq, beat;

  always_comb begin
    wantReq  = dir ? revReq : fwdReq;
    oppReq   = dir ? fwdReq : revReq;
    beat     = (state == ST_GNT) && wantReq && stb;
    stateNxt = state;
    dirNxt   = dir;
    cntNxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (wantReq) begin
          stateNxt = ST_GNT;
          cntNxt   = '0;
        end else if (oppReq) begin
          stateNxt = ST_TURN;
          dirNxt   = ~dir;
          cntNxt   = TURN_LOAD;
        end
      end
      ST_GNT: begin
        if (!wantReq) begin
          stateNxt = ST_IDLE;
          cntNxt   = '0;
        end else if (beat) begin
          // The beat that completes the burst either hands over or restarts the window.
          if (cnt == BURST_LAST) begin
            if (oppReq) begin
              stateNxt = ST_TURN;
              dirNxt   = ~dir;
              cntNxt   = TURN_LOAD;
            end else begin
              cntNxt = '0;
            end
          end else begin
            cntNxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_TURN: begin
        // dir already holds the new direction, so wantReq refers to the side being turned to.
        if (cnt <= CNT_W'(1)) begin
          stateNxt = wantReq ? ST_GNT : ST_IDLE;
          cntNxt   = '0;
        end else begin
          cntNxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        stateNxt = ST_IDLE;
        dirNxt   = DIR_FWD;
        cntNxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      dir    <= DIR_FWD;
      cnt    <= '0;
      oe     <= DIR_FWD;
      gntFwd <= 1'b0;
      gntRev <= 1'b0;
    end else begin
      state  <= stateNxt;
      dir    <= dirNxt;
      cnt    <= cntNxt;
      oe     <= dirNxt;
      gntFwd <= (stateNxt == ST_GNT) && (dirNxt == DIR_FWD);
      gntRev <= (stateNxt == ST_GNT) && (dirNxt == DIR_REV);
    end
  end

endmodule

// File: rtl/dataexch_ctrl.sv
// Drives oe0/oe1 and grants for the 32-bit A/B and C/D exchange buffer; two independent channels.
// Latency: all outputs registered, 1-cycle grant; requesters hold req and wait for their grant.
module dataexch_ctrl
  import dataexch_pkg::*;
#(
  parameter int TURN_CYC  = TURN_CYC_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req_ab,
  input  logic req_ba,
  input  logic stb0,
  input  logic req_cd,
  input  logic req_dc,
  input  logic stb1,
  output logic oe0,
  output logic oe1,
  output logic gnt_ab,
  output logic gnt_ba,
  output logic gnt_cd,
  output logic gnt_dc
);

  dirctl_chan #(
    .TURN_CYC (TURN_CYC),
    .BURST_MAX(BURST_MAX),
    .CNT_W    (CNT_W)
  ) chan0 (
    .clk   (clk),
    .rst   (rst),
    .fwdReq(req_ab),
    .revReq(req_ba),
    .stb   (stb0),
    .oe    (oe0),
    .gntFwd(gnt_ab),
    .gntRev(gnt_ba)
  );

  dirctl_chan #(
    .TURN_CYC (TURN_CYC),
    .BURST_MAX(BURST_MAX),
    .CNT_W    (CNT_W)
  ) chan1 (
    .clk   (clk),
    .rst   (rst),
    .fwdReq(req_cd),
    .revReq(req_dc),
    .stb   (stb1),
    .oe    (oe1),
    .gntFwd(gnt_cd),
    .gntRev(gnt_dc)
  );

endmodule

// File: tb/tb_dataexch_ctrl.sv
// Bench for dataexch_ctrl: directed literal checks plus randomized traffic against a per-channel model.
module tb_dataexch_ctrl;

  localparam int TURN  = 2;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst;
  logic req_ab, req_ba, stb0, req_cd, req_dc, stb1;
  logic oe0, oe1, gnt_ab, gnt_ba, gnt_cd, gnt_dc;

  always #5 clk = ~clk;

  dataexch_ctrl #(
    .TURN_CYC (TURN),
    .BURST_MAX(BURST),
    .CNT_W    (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req_ab(req_ab),
    .req_ba(req_ba),
    .stb0  (stb0),
    .req_cd(req_cd),
    .req_dc(req_dc),
    .stb1  (stb1),
    .oe0   (oe0),
    .oe1   (oe1),
    .gnt_ab(gnt_ab),
    .gnt_ba(gnt_ba),
    .gnt_cd(gnt_cd),
    .gnt_dc(gnt_dc)
  );

  int checks = 0;
  int errors = 0;
  bit chkEn  = 1'b0;

  // Model per channel: who owns the bus, how many dead cycles remain, beats in this grant.
  bit mDir[2];
  bit mGrant[2];
  int mDead[2];
  int mBeats[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task modelStep(input int c, input bit f, input bit r, input bit s);
    bit want, opp;
    want = mDir[c] ? r : f;
    opp  = mDir[c] ? f : r;
    if (mDead[c] > 0) begin
      mDead[c]--;
      if (mDead[c] == 0) mGrant[c] = mDir[c] ? r : f;
    end else if (mGrant[c]) begin
      if (!want) begin
        mGrant[c] = 1'b0;
        mBeats[c] = 0;
      end else if (s) begin
        mBeats[c]++;
        if (mBeats[c] == BURST) begin
          mBeats[c] = 0;
          if (opp) begin
            mDir[c]   = !mDir[c];
            mGrant[c] = 1'b0;
            mDead[c]  = TURN;
          end
        end
      end
    end else if (want) begin
      mGrant[c] = 1'b1;
      mBeats[c] = 0;
    end else if (opp) begin
      mDir[c]  = !mDir[c];
      mDead[c] = TURN;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        mDir[c]   = 1'b0;
        mGrant[c] = 1'b0;
        mDead[c]  = 0;
        mBeats[c] = 0;
      end
    end else begin
      modelStep(0, req_ab, req_ba, stb0);
      modelStep(1, req_cd, req_dc, stb1);
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("m_oe0", oe0, mDir[0]);
      chk("m_gnt_ab", gnt_ab, mGrant[0] && !mDir[0]);
      chk("m_gnt_ba", gnt_ba, mGrant[0] && mDir[0]);
      chk("m_oe1", oe1, mDir[1]);
      chk("m_gnt_cd", gnt_cd, mGrant[1] && !mDir[1]);
      chk("m_gnt_dc", gnt_dc, mGrant[1] && mDir[1]);
      chk("excl0", gnt_ab & gnt_ba, 0);
      chk("excl1", gnt_cd & gnt_dc, 0);
    end
  end

  logic [15:0] abPat, baPat;

  initial begin
    rst = 1'b1;
    req_ab = 0; req_ba = 0; stb0 = 0;
    req_cd = 0; req_dc = 0; stb1 = 0;
    @(posedge clk);
    chkEn = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_oe0", oe0, 0);
    chk("rst_gnt_ab", gnt_ab, 0);
    chk("rst_gnt_ba", gnt_ba, 0);
    chk("rst_oe1", oe1, 0);
    chk("rst_gnt_cd", gnt_cd, 0);
    chk("rst_gnt_dc", gnt_dc, 0);

    // Single forward requester streaming 20 beats: no turnaround, never yields.
    req_ab = 1; stb0 = 1;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stream_gnt_ab", gnt_ab, 1);
      chk("stream_gnt_ba", gnt_ba, 0);
      chk("stream_oe0", oe0, 0);
      chk("stream_gnt_cd", gnt_cd, 0);
      chk("stream_oe1", oe1, 0);
    end
    req_ab = 0; stb0 = 0;
    repeat (3) @(negedge clk);

    // Reverse request from IDLE with dir=0: oe flips at once, two dead cycles, then grant.
    req_ba = 1;
    @(posedge clk);
    @(negedge clk);
    chk("turn_oe0_t1", oe0, 1);
    chk("turn_gnt_ab_t1", gnt_ab, 0);
    chk("turn_gnt_ba_t1", gnt_ba, 0);
    @(negedge clk);
    chk("turn_oe0_t2", oe0, 1);
    chk("turn_gnt_ba_t2", gnt_ba, 0);
    @(negedge clk);
    chk("turn_gnt_ba_t3", gnt_ba, 1);
    req_ba = 0;
    repeat (3) @(negedge clk);

    // Both directions contending on channel 0 while channel 1 streams forward.
    req_cd = 1; stb1 = 1;
    repeat (2) @(negedge clk);
    req_ab = 1; req_ba = 1; stb0 = 1;
    baPat = 16'hF00F;
    abPat = 16'h03C0;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("burst_gnt_ba", gnt_ba, baPat[i]);
      chk("burst_gnt_ab", gnt_ab, abPat[i]);
      chk("burst_gnt_cd", gnt_cd, 1);
      chk("burst_oe1", oe1, 0);
    end
    req_ab = 0; req_ba = 0; stb0 = 0;
    req_cd = 0; stb1 = 0;

    // Reset in the middle of a turnaround.
    rst = 1;
    @(negedge clk);
    rst = 0;
    req_ba = 1;
    @(posedge clk);
    #1 rst = 1; req_ba = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rstturn_oe0", oe0, 0);
    chk("rstturn_gnt_ab", gnt_ab, 0);
    chk("rstturn_gnt_ba", gnt_ba, 0);
    rst = 0;
    req_ab = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rstturn_fresh_gnt_ab", gnt_ab, 1);

    // Randomized traffic on both channels with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) req_ab = ~req_ab;
      if ($urandom_range(7) == 0) req_ba = ~req_ba;
      if ($urandom_range(7) == 0) req_cd = ~req_cd;
      if ($urandom_range(7) == 0) req_dc = ~req_dc;
      stb0 = ($urandom_range(3) != 0);
      stb1 = ($urandom_range(3) != 0);
      rst  = ($urandom_range(299) == 0);
    end
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
